// File: rtl/ps2_rx_packet.sv
// PS/2 device-to-host receiver: oversampled, glitch-filtered, framed and packetised.
// Optional PS2_MOUSE_SYNC_EN: drop index-0 bytes with bit 3 clear to realign mouse packets.
module ps2_rx_packet #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int PKT_BYTES   = 3
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   ps2ck,
  input  logic                   ps2dt,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  output logic [8*PKT_BYTES-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  logic [1:0] raw;
  logic [1:0] filt;
  logic       ck_sync;
  logic       ck_f;
  logic       dt_f;

  assign raw  = {ps2dt, ps2ck};
  assign ck_f = filt[0];
  assign dt_f = filt[1];

  // Synchronisers stay unreset so a line held low through reset is visible right after it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic          s1_q;
    logic          s2_q;
    logic          f_q;
    logic [FW-1:0] cnt_q;

    always_ff @(posedge CLOCK) begin
      s1_q <= raw[gi];
      s2_q <= s1_q;
      if (RESET) begin
        f_q   <= 1'b1;
        cnt_q <= '0;
      end else if (s2_q == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FW'(FILTER_LEN - 1)) begin
        f_q   <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign filt[gi] = f_q;

    if (gi == 0) begin : g_ck
      assign ck_sync = s2_q;
    end
  end

  logic          ck_prev_q, ck_prev_d;
  logic          arm_q, arm_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic [8*PKT_BYTES-1:0] pkt_data_q, pkt_data_d;
  logic [8*PKT_BYTES-1:0] pkt_next;
  logic          byte_valid_q, byte_valid_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic          fall;
  logic          accept;
  logic          par_ok;
  logic          busy_int;

  // No edge is honoured until the raw clock has been seen high since reset.
  assign fall     = arm_q & ck_prev_q & ~ck_f;
  assign busy_int = (bit_cnt_q != 4'd0) || (idx_q != '0);
  assign par_ok   = ^{shift_q, par_q};

  for (genvar gi = 0; gi < PKT_BYTES; gi++) begin : g_slot
    logic [7:0] slot_q;

    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        slot_q <= '0;
      end else if (accept && idx_q == IW'(gi)) begin
        slot_q <= shift_q;
      end
    end

    assign pkt_next[8*gi +: 8] = (idx_q == IW'(gi)) ? shift_q : slot_q;
  end

  always_comb begin
    ck_prev_d     = ck_f;
    arm_d         = arm_q | ck_sync;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    to_cnt_d      = to_cnt_q;
    idx_d         = idx_q;
    byte_data_d   = byte_data_q;
    pkt_data_d    = pkt_data_q;
    byte_valid_d  = 1'b0;
    pkt_valid_d   = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    accept        = 1'b0;

    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (!dt_f) begin
          bit_cnt_d = 4'd1;
        end else begin
          frame_err_d = 1'b1;
          idx_d       = '0;
        end
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {dt_f, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        par_d     = dt_f;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d    = 4'd0;
        parity_err_d = ~par_ok;
        frame_err_d  = ~dt_f;
        if (par_ok && dt_f) begin
`ifdef PS2_MOUSE_SYNC_EN
          if (idx_q == '0 && !shift_q[3]) begin
            frame_err_d = 1'b1;
          end else begin
            accept = 1'b1;
          end
`else
          accept = 1'b1;
`endif
        end else begin
          idx_d = '0;
        end
      end
    end else if (busy_int) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        timeout_err_d = 1'b1;
        to_cnt_d      = '0;
        bit_cnt_d     = 4'd0;
        idx_d         = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end

    if (accept) begin
      byte_data_d  = shift_q;
      byte_valid_d = 1'b1;
      if (idx_q == IW'(PKT_BYTES - 1)) begin
        pkt_data_d  = pkt_next;
        pkt_valid_d = 1'b1;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ck_prev_q     <= 1'b1;
      arm_q         <= 1'b0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      to_cnt_q      <= '0;
      idx_q         <= '0;
      byte_data_q   <= '0;
      pkt_data_q    <= '0;
      byte_valid_q  <= 1'b0;
      pkt_valid_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ck_prev_q     <= ck_prev_d;
      arm_q         <= arm_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      to_cnt_q      <= to_cnt_d;
      idx_q         <= idx_d;
      byte_data_q   <= byte_data_d;
      pkt_data_q    <= pkt_data_d;
      byte_valid_q  <= byte_valid_d;
      pkt_valid_q   <= pkt_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign pkt_data    = pkt_data_q;
  assign pkt_valid   = pkt_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_int;

endmodule

// File: tb/tb_ps2_rx_packet.sv
// Directed bench for ps2_rx_packet: framing, packets, errors, timeout, glitches, reset.
`timescale 1ns/1ps
module tb_ps2_rx_packet;
  localparam int FL = 4;
  localparam int TO = 200;
  localparam int PB = 3;
  localparam int H  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2ck = 1'b1;
  logic        ps2dt = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [23:0] pkt_data;
  logic        pkt_valid;
  logic        parity_err;
  logic        frame_err;
  logic        timeout_err;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int n_bv = 0, n_pv = 0, n_pe = 0, n_fe = 0, n_te = 0;

  always #5 clk = ~clk;

  ps2_rx_packet #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .PKT_BYTES(PB)) dut (
    .CLOCK(clk), .RESET(rst), .ps2ck(ps2ck), .ps2dt(ps2dt),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .parity_err(parity_err), .frame_err(frame_err),
    .timeout_err(timeout_err), .busy(busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid)  n_bv++;
      if (pkt_valid)   n_pv++;
      if (parity_err)  n_pe++;
      if (frame_err)   n_fe++;
      if (timeout_err) n_te++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2dt = b;
    wait_cycles(H);
    ps2ck = 1'b0;
    wait_cycles(H);
    ps2ck = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    ps2dt = 1'b1;
    wait_cycles(2 * H);
    $display("tx frame data=%02h par=%0d stop=%0d", d, p, s);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1);
  endtask

  task automatic send_glitch_frame(input logic [7:0] d);
    logic [10:0] bits;
    bits = {1'b1, ~^d, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2dt = bits[i];
      wait_cycles(H / 2);
      ps2ck = 1'b0;
      wait_cycles(1);
      ps2ck = 1'b1;
      wait_cycles(H / 2 - 1);
      ps2ck = 1'b0;
      wait_cycles(H);
      ps2ck = 1'b1;
    end
    ps2dt = 1'b1;
    wait_cycles(2 * H);
    $display("tx glitched frame data=%02h", d);
  endtask

  task automatic flush();
    wait_cycles(TO + 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(2);
    total++; if (byte_data !== 8'h00) $display("FAIL reset_byte_data got=%h want=00", byte_data); else passed++;
    total++; if (pkt_data !== 24'h0) $display("FAIL reset_pkt_data got=%h want=000000", pkt_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    total++; if (byte_valid !== 1'b0) $display("FAIL reset_byte_valid got=%b want=0", byte_valid); else passed++;
    total++; if (pkt_valid !== 1'b0) $display("FAIL reset_pkt_valid got=%b want=0", pkt_valid); else passed++;
    total++; if ({parity_err, frame_err, timeout_err} !== 3'b000)
      $display("FAIL reset_errs got=%b want=000", {parity_err, frame_err, timeout_err}); else passed++;
  endtask

  task automatic test_single();
    int bv0, er0, te0;
    bv0 = n_bv; er0 = n_pe + n_fe; te0 = n_te;
    send_good(8'h5A);
    total++; if (n_bv - bv0 !== 1) $display("FAIL single_bv got=%0d want=1", n_bv - bv0); else passed++;
    total++; if (byte_data !== 8'h5A) $display("FAIL single_data got=%h want=5a", byte_data); else passed++;
    total++; if (n_pe + n_fe - er0 !== 0) $display("FAIL single_errs got=%0d want=0", n_pe + n_fe - er0); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy_mid got=%b want=1", busy); else passed++;
    flush();
    total++; if (n_te - te0 !== 1) $display("FAIL single_te got=%0d want=1", n_te - te0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_end got=%b want=0", busy); else passed++;
  endtask

  task automatic test_packet();
    int bv0, pv0, er0;
    bv0 = n_bv; pv0 = n_pv; er0 = n_pe + n_fe + n_te;
    send_good(8'h08);
    send_good(8'h10);
    send_good(8'hF0);
    total++; if (n_bv - bv0 !== 3) $display("FAIL pkt_bv got=%0d want=3", n_bv - bv0); else passed++;
    total++; if (n_pv - pv0 !== 1) $display("FAIL pkt_pv got=%0d want=1", n_pv - pv0); else passed++;
    total++; if (pkt_data !== 24'hF01008) $display("FAIL pkt_data got=%h want=f01008", pkt_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL pkt_busy got=%b want=0", busy); else passed++;
    total++; if (n_pe + n_fe + n_te - er0 !== 0) $display("FAIL pkt_errs got=%0d want=0", n_pe + n_fe + n_te - er0); else passed++;
  endtask

  task automatic test_parity();
    int bv0, pv0, pe0, fe0;
    send_good(8'h18);
    bv0 = n_bv; pe0 = n_pe; fe0 = n_fe;
    send_frame(8'h5A, 1'b0, 1'b1);
    total++; if (n_pe - pe0 !== 1) $display("FAIL par_pe got=%0d want=1", n_pe - pe0); else passed++;
    total++; if (n_bv - bv0 !== 0) $display("FAIL par_bv got=%0d want=0", n_bv - bv0); else passed++;
    total++; if (byte_data !== 8'h18) $display("FAIL par_data_kept got=%h want=18", byte_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL par_busy got=%b want=0", busy); else passed++;
    send_frame(8'h5A, 1'b1, 1'b0);
    total++; if (n_fe - fe0 !== 1) $display("FAIL stop_fe got=%0d want=1", n_fe - fe0); else passed++;
    total++; if (n_pe - pe0 !== 1) $display("FAIL stop_pe got=%0d want=1", n_pe - pe0); else passed++;
    pv0 = n_pv;
    send_good(8'h08);
    send_good(8'h77);
    send_good(8'h66);
    total++; if (n_pv - pv0 !== 1) $display("FAIL par_next_pv got=%0d want=1", n_pv - pv0); else passed++;
    total++; if (pkt_data !== 24'h667708) $display("FAIL par_next_pkt got=%h want=667708", pkt_data); else passed++;
  endtask

  task automatic test_timeout();
    int te0, bv0, fe0, first;
    logic [4:0] bits;
    bits = 5'b11010;
    te0 = n_te;
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    ps2dt = bits[4];
    wait_cycles(H);
    ps2ck = 1'b0;
    first = -1;
    for (int i = 1; i <= FL + TO + 60; i++) begin
      wait_cycles(1);
      if (i == H) ps2ck = 1'b1;
      if (timeout_err && first < 0) first = i;
    end
    ps2dt = 1'b1;
    total++; if (first !== FL + 3 + TO) $display("FAIL to_latency got=%0d want=%0d", first, FL + 3 + TO); else passed++;
    total++; if (n_te - te0 !== 1) $display("FAIL to_count got=%0d want=1", n_te - te0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL to_busy got=%b want=0", busy); else passed++;
    bv0 = n_bv; fe0 = n_fe;
    send_good(8'h33);
`ifdef PS2_MOUSE_SYNC_EN
    total++; if (n_fe - fe0 !== 1) $display("FAIL to_next_fe got=%0d want=1", n_fe - fe0); else passed++;
    total++; if (n_bv - bv0 !== 0) $display("FAIL to_next_bv got=%0d want=0", n_bv - bv0); else passed++;
`else
    total++; if (n_bv - bv0 !== 1) $display("FAIL to_next_bv got=%0d want=1", n_bv - bv0); else passed++;
    total++; if (byte_data !== 8'h33) $display("FAIL to_next_data got=%h want=33", byte_data); else passed++;
`endif
    flush();
  endtask

  task automatic test_glitch();
    int bv0, er0;
    bv0 = n_bv; er0 = n_pe + n_fe;
    send_good(8'h08);
    send_glitch_frame(8'hA5);
    total++; if (n_bv - bv0 !== 2) $display("FAIL glitch_bv got=%0d want=2", n_bv - bv0); else passed++;
    total++; if (byte_data !== 8'hA5) $display("FAIL glitch_data got=%h want=a5", byte_data); else passed++;
    total++; if (n_pe + n_fe - er0 !== 0) $display("FAIL glitch_errs got=%0d want=0", n_pe + n_fe - er0); else passed++;
    flush();
  endtask

  task automatic test_sync();
    int bv0, pv0, fe0;
    bv0 = n_bv; pv0 = n_pv; fe0 = n_fe;
    send_good(8'h00);
    send_good(8'h08);
    send_good(8'h01);
    send_good(8'h02);
    total++; if (n_pv - pv0 !== 1) $display("FAIL sync_pv got=%0d want=1", n_pv - pv0); else passed++;
`ifdef PS2_MOUSE_SYNC_EN
    total++; if (n_fe - fe0 !== 1) $display("FAIL sync_fe got=%0d want=1", n_fe - fe0); else passed++;
    total++; if (n_bv - bv0 !== 3) $display("FAIL sync_bv got=%0d want=3", n_bv - bv0); else passed++;
    total++; if (pkt_data !== 24'h020108) $display("FAIL sync_pkt got=%h want=020108", pkt_data); else passed++;
`else
    total++; if (n_fe - fe0 !== 0) $display("FAIL sync_fe got=%0d want=0", n_fe - fe0); else passed++;
    total++; if (n_bv - bv0 !== 4) $display("FAIL sync_bv got=%0d want=4", n_bv - bv0); else passed++;
    total++; if (pkt_data !== 24'h010800) $display("FAIL sync_pkt got=%h want=010800", pkt_data); else passed++;
`endif
    flush();
  endtask

  task automatic test_reset_midframe();
    int bv0, fe0, pe0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2dt = 1'b0;
    wait_cycles(H);
    ps2ck = 1'b0;
    wait_cycles(10);
    rst = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    fe0 = n_fe; pe0 = n_pe;
    wait_cycles(30);
    total++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b want=0", busy); else passed++;
    total++; if (byte_data !== 8'h00) $display("FAIL mid_byte_data got=%h want=00", byte_data); else passed++;
    total++; if (pkt_data !== 24'h0) $display("FAIL mid_pkt_data got=%h want=000000", pkt_data); else passed++;
    total++; if (n_fe - fe0 !== 0) $display("FAIL mid_no_edge_fe got=%0d want=0", n_fe - fe0); else passed++;
    ps2ck = 1'b1;
    ps2dt = 1'b1;
    wait_cycles(H);
    bv0 = n_bv;
    send_good(8'h3C);
    total++; if (n_bv - bv0 !== 1) $display("FAIL mid_next_bv got=%0d want=1", n_bv - bv0); else passed++;
    total++; if (byte_data !== 8'h3C) $display("FAIL mid_next_data got=%h want=3c", byte_data); else passed++;
    total++; if (n_fe + n_pe - fe0 - pe0 !== 0) $display("FAIL mid_next_errs got=%0d want=0", n_fe + n_pe - fe0 - pe0); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_packet();
    test_parity();
    test_timeout();
    test_glitch();
    test_sync();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
